// File: rtl/sand_sweeper_if.sv
// Playfield RAM port and sand-updater port of the sweeper, bundled as one interface.
// master = sweeper side, slave = RAM + combinational updater side.
interface sand_sweeper_if #(
    parameter int unsigned ADDR_W = 15
);
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic              mem_wr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic [31:0]       upd_region;
    logic [31:0]       upd_floor;
    logic              upd_screenbegin;
    logic              upd_screenend;
    logic              upd_screenbottom;
    logic [31:0]       upd_new_region;
    logic [31:0]       upd_new_floor;

    modport master (
        output mem_addr, mem_rd, mem_wr, mem_wdata,
        output upd_region, upd_floor, upd_screenbegin, upd_screenend, upd_screenbottom,
        input  mem_rdata, upd_new_region, upd_new_floor
    );

    modport slave (
        input  mem_addr, mem_rd, mem_wr, mem_wdata,
        input  upd_region, upd_floor, upd_screenbegin, upd_screenend, upd_screenbottom,
        output mem_rdata, upd_new_region, upd_new_floor
    );
endinterface

// File: rtl/sand_sweeper.sv
// Per-frame sweep of the packed sand playfield: read region/floor words, hand them to the
// combinational updater, write the results back. Bottom row first, 5 cycles per word.
module sand_sweeper #(
    parameter int unsigned WORDS_PER_ROW = 40,
    parameter int unsigned ROWS          = 480,
    parameter int unsigned ADDR_W        = 15
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    output logic           busy,
    output logic           done,
    sand_sweeper_if.master bus
);
    localparam int unsigned ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned WORD_W = (WORDS_PER_ROW > 1) ? $clog2(WORDS_PER_ROW) : 1;

    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(ROWS - 1);
    localparam logic [WORD_W-1:0] WORD_LAST = WORD_W'(WORDS_PER_ROW - 1);
    localparam logic [ADDR_W-1:0] BASE_LAST = ADDR_W'((ROWS - 1) * WORDS_PER_ROW);
    localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(WORDS_PER_ROW);

    typedef enum logic [2:0] {
        st_idle, st_rd_r, st_rd_f, st_cap_f, st_wr_r, st_wr_f, st_done
    } state_e;

    state_e            state_q, state_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [31:0]       region_q, region_d;
    logic [31:0]       floor_q, floor_d;

    logic [ADDR_W-1:0] reg_addr;
    logic [ADDR_W-1:0] flr_addr;
    logic              bottom;

    // Row base is stepped down per row so no multiplier is needed for the address.
    assign reg_addr = base_q + ADDR_W'(word_q);
    assign flr_addr = reg_addr + ROW_STEP;
    assign bottom   = (row_q == ROW_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= st_idle;
            row_q    <= '0;
            word_q   <= '0;
            base_q   <= '0;
            region_q <= '0;
            floor_q  <= '0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            word_q   <= word_d;
            base_q   <= base_d;
            region_q <= region_d;
            floor_q  <= floor_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        row_d         = row_q;
        word_d        = word_q;
        base_d        = base_q;
        region_d      = region_q;
        floor_d       = floor_q;
        bus.mem_addr  = '0;
        bus.mem_rd    = 1'b0;
        bus.mem_wr    = 1'b0;
        bus.mem_wdata = '0;

        unique case (state_q)
            st_idle: begin
                if (start) begin
                    row_d   = ROW_LAST;
                    word_d  = '0;
                    base_d  = BASE_LAST;
                    state_d = st_rd_r;
                end
            end
            st_rd_r: begin
                bus.mem_rd   = 1'b1;
                bus.mem_addr = reg_addr;
                state_d      = st_rd_f;
            end
            st_rd_f: begin
                region_d = bus.mem_rdata;
                if (bottom) begin
                    floor_d = '1;  // below the last row is solid wall
                end else begin
                    bus.mem_rd   = 1'b1;
                    bus.mem_addr = flr_addr;
                end
                state_d = st_cap_f;
            end
            st_cap_f: begin
                if (!bottom) begin
                    floor_d = bus.mem_rdata;
                end
                state_d = st_wr_r;
            end
            st_wr_r: begin
                bus.mem_wr    = 1'b1;
                bus.mem_addr  = reg_addr;
                bus.mem_wdata = bus.upd_new_region;
                state_d       = st_wr_f;
            end
            st_wr_f: begin
                bus.mem_wr    = !bottom;
                bus.mem_addr  = flr_addr;
                bus.mem_wdata = bus.upd_new_floor;
                state_d       = st_rd_r;
                if (word_q != WORD_LAST) begin
                    word_d = word_q + WORD_W'(1);
                end else begin
                    word_d = '0;
                    if (row_q == '0) begin
                        state_d = st_done;
                    end else begin
                        row_d  = row_q - ROW_W'(1);
                        base_d = base_q - ROW_STEP;
                    end
                end
            end
            st_done: begin
                state_d = st_idle;
            end
            default: begin
                state_d = st_idle;
            end
        endcase
    end

    assign busy = (state_q != st_idle);
    assign done = (state_q == st_done);

    assign bus.upd_region       = region_q;
    assign bus.upd_floor        = floor_q;
    assign bus.upd_screenbegin  = (word_q == '0);
    assign bus.upd_screenend    = (word_q == WORD_LAST);
    assign bus.upd_screenbottom = bottom;
endmodule

// File: tb/tb_sand_sweeper.sv
// Bench for sand_sweeper: RAM and updater stub around the DUT, a per-cycle expectation
// queue built from the sweep rules, and a negedge compare process.
module tb_sand_sweeper;
    localparam int unsigned WPR    = 3;
    localparam int unsigned NROWS  = 3;
    localparam int unsigned AW     = 4;
    localparam int unsigned NWORDS = WPR * NROWS;
    localparam int unsigned SWEEP  = 5 * NWORDS;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic busy;
    logic done;

    sand_sweeper_if #(.ADDR_W(AW)) bus ();

    sand_sweeper #(
        .WORDS_PER_ROW(WPR),
        .ROWS         (NROWS),
        .ADDR_W       (AW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .start(start),
        .busy (busy),
        .done (done),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Playfield RAM with 1-cycle read latency; ld_* preloads it while the DUT is idle.
    logic [31:0]   ram [16];
    logic          ld_en   = 1'b0;
    logic [AW-1:0] ld_addr = '0;
    logic [31:0]   ld_data = '0;

    always @(posedge clk) begin
        if (ld_en) ram[ld_addr] <= ld_data;
        else if (bus.mem_wr) ram[bus.mem_addr] <= bus.mem_wdata;
        if (bus.mem_rd) bus.mem_rdata <= ram[bus.mem_addr];
    end

    logic [31:0] xmask = '0;
    logic [31:0] fadd  = '0;
    assign bus.upd_new_region = bus.upd_region ^ xmask;
    assign bus.upd_new_floor  = bus.upd_floor + fadd;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic          busy, done, rd, wr;
        logic [AW-1:0] addr;
        logic [31:0]   wdata;
        logic          upd;
        logic [31:0]   region, floor;
        logic          flags, sb, se, sbot;
    } exp_t;

    exp_t        expq [$];
    exp_t        cur;
    logic [31:0] plan      [NWORDS];  // model RAM after every queued sweep
    logic [31:0] committed [NWORDS];  // model RAM after writes already checked
    bit          armed = 1'b0;

    // Expected per-cycle view of one full sweep, evolving the model RAM as it goes.
    task automatic push_sweep();
        exp_t        e;
        int          ra, fa;
        bit          bot;
        logic [31:0] rg, fl, nr, nf;
        for (int r = int'(NROWS) - 1; r >= 0; r--) begin
            for (int w = 0; w < int'(WPR); w++) begin
                ra  = r * int'(WPR) + w;
                fa  = ra + int'(WPR);
                bot = (r == int'(NROWS) - 1);
                rg  = plan[ra];
                fl  = bot ? 32'hFFFF_FFFF : plan[fa];
                nr  = rg ^ xmask;
                nf  = fl + fadd;
                plan[ra] = nr;
                if (!bot) plan[fa] = nf;
                e = '{default: '0};
                e.busy = 1'b1; e.flags = 1'b1;
                e.sb = (w == 0); e.se = (w == int'(WPR) - 1); e.sbot = bot;
                e.rd = 1'b1; e.addr = AW'(ra);
                expq.push_back(e);
                e.rd = !bot; e.addr = AW'(fa);
                expq.push_back(e);
                e.rd = 1'b0;
                expq.push_back(e);
                e.wr = 1'b1; e.addr = AW'(ra); e.wdata = nr;
                e.upd = 1'b1; e.region = rg; e.floor = fl;
                expq.push_back(e);
                e.wr = !bot; e.addr = AW'(fa); e.wdata = nf;
                expq.push_back(e);
            end
        end
        e = '{default: '0};
        e.busy = 1'b1; e.done = 1'b1;
        expq.push_back(e);
    endtask

    always @(negedge clk) begin
        if (armed) begin
            if (expq.size() != 0) begin
                cur = expq.pop_front();
                chk("busy", 32'(busy), 32'(cur.busy));
                chk("done", 32'(done), 32'(cur.done));
                chk("mem_rd", 32'(bus.mem_rd), 32'(cur.rd));
                chk("mem_wr", 32'(bus.mem_wr), 32'(cur.wr));
                if (cur.rd || cur.wr) chk("mem_addr", 32'(bus.mem_addr), 32'(cur.addr));
                if (cur.wr) chk("mem_wdata", bus.mem_wdata, cur.wdata);
                if (cur.upd) begin
                    chk("upd_region", bus.upd_region, cur.region);
                    chk("upd_floor", bus.upd_floor, cur.floor);
                end
                if (cur.flags) begin
                    chk("screenbegin", 32'(bus.upd_screenbegin), 32'(cur.sb));
                    chk("screenend", 32'(bus.upd_screenend), 32'(cur.se));
                    chk("screenbottom", 32'(bus.upd_screenbottom), 32'(cur.sbot));
                end
                if (cur.wr) committed[cur.addr] = cur.wdata;
            end else begin
                chk("idle_busy", 32'(busy), 32'd0);
                chk("idle_done", 32'(done), 32'd0);
                chk("idle_mem_rd", 32'(bus.mem_rd), 32'd0);
                chk("idle_mem_wr", 32'(bus.mem_wr), 32'd0);
            end
        end
    end

    task automatic load(input int idx, input logic [31:0] d);
        @(posedge clk);
        #1 ld_en = 1'b1; ld_addr = AW'(idx); ld_data = d;
        if (idx < int'(NWORDS)) begin
            plan[idx]      = d;
            committed[idx] = d;
        end
    endtask

    task automatic load_end();
        @(posedge clk);
        #1 ld_en = 1'b0;
    endtask

    // Returns 1 ns after the edge that samples start, with the sweep already queued.
    task automatic do_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        push_sweep();
    endtask

    task automatic wait_drain();
        int n = 0;
        while (expq.size() != 0 && n < 1000) begin
            @(posedge clk);
            n++;
        end
        if (expq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d cycles still queued, expected 0", expq.size());
            expq.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int cyc;

        for (int i = 0; i < 16; i++) load(i, 32'h0);
        load_end();
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_mem_rd", 32'(bus.mem_rd), 32'd0);
        chk("rst_mem_wr", 32'(bus.mem_wr), 32'd0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
        chk("rst_upd_region", bus.upd_region, 32'd0);
        chk("rst_upd_floor", bus.upd_floor, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        armed = 1'b1;

        // Sweep 1: zeroed RAM, region^1 / floor+1 stub, stray start at cycle 10.
        xmask = 32'h1;
        fadd  = 32'h1;
        do_start();
        repeat (4) @(negedge clk);
        chk("lit_bottom_wr_r_floor", bus.upd_floor, 32'hFFFF_FFFF);
        chk("lit_bottom_flag", 32'(bus.upd_screenbottom), 32'd1);
        chk("lit_bottom_wr_r_addr", 32'(bus.mem_addr), 32'd6);
        chk("lit_bottom_wr_r_wr", 32'(bus.mem_wr), 32'd1);
        repeat (6) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cyc = 10;
        while (cyc < 500) begin
            @(negedge clk);
            cyc++;
            if (done) break;
        end
        chk("lit_done_cycle", 32'(cyc), 32'd46);
        wait_drain();
        for (int i = 0; i < int'(WPR); i++) chk("lit_row0_word", ram[i], 32'd1);
        for (int i = int'(WPR); i < int'(NWORDS); i++) chk("lit_row12_word", ram[i], 32'd2);

        // Sweep 2: random data, random stray starts, start held across DONE into IDLE.
        for (int i = 0; i < int'(NWORDS); i++) load(i, $urandom);
        load_end();
        xmask = $urandom;
        fadd  = $urandom;
        do_start();
        for (int i = 1; i < int'(SWEEP); i++) begin
            @(posedge clk);
            #1 start = ($urandom_range(0, 9) == 0);
        end
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        push_sweep();
        wait_drain();

        // Reset in the middle of a sweep, then a clean restart.
        for (int i = 0; i < int'(NWORDS); i++) load(i, $urandom);
        load_end();
        do_start();
        repeat (11) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        expq.delete();
        for (int i = 0; i < int'(NWORDS); i++) plan[i] = committed[i];
        @(negedge clk);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_mem_rd", 32'(bus.mem_rd), 32'd0);
        chk("abort_mem_wr", 32'(bus.mem_wr), 32'd0);
        repeat (4) @(posedge clk);
        #1;
        do_start();
        wait_drain();

        for (int s = 0; s < 3; s++) begin
            for (int i = 0; i < int'(NWORDS); i++) load(i, $urandom);
            load_end();
            xmask = $urandom;
            fadd  = $urandom;
            do_start();
            wait_drain();
        end

        for (int i = 0; i < int'(NWORDS); i++) chk("final_ram", ram[i], plan[i]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
